ly_hit_injector: RTL and testbench
==================================

# ly_hit_injector

Drives six 32-bit layer hit buses with pre-loaded wire-group hit frames. It is the source end of the chamber one-shot front end. Its `ly0`..`ly5` outputs connect directly to the one-shot stage inputs during self-test, replacing the real anode hits. Frames are written over a simple load port and then replayed as fixed-width pulses separated by programmable gaps. Replay pauses with `trig_stop`, in the same way the one-shot stage does.

## Interface
- `DEPTH`, 8: number of stored frames; power of two, 2..16.
- `PULSE_LEN`, 2: clocks each frame is driven; at least 1.
- `GAP_LEN`, 3: clocks of all-zero output after each frame; 0 allowed.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `wr_en` in 1: write strobe for the frame store.
- `wr_addr` in log2(DEPTH): frame index to write.
- `wr_layer` in 3: layer select, 0..5; values 6 and 7 are ignored (no write).
- `wr_data` in 32: hit bits for the selected layer of the selected frame.
- `last_frame` in log2(DEPTH): index of the final frame to play; sampled on `start`.
- `start` in 1: single-cycle request to begin replay.
- `loop` in 1: repeat the sequence continuously; sampled on `start`; see Configuration.
- `trig_stop` in 1: pause request.
- `ly0`..`ly5` out 32 each: registered layer hit outputs.
- `busy` out 1: high while not IDLE.
- `done` out 1: one-clock pulse when a sequence ends.

## Operation
- Frame store: DEPTH × 6 × 32 bits.
  - A write updates one layer word per clock.
  - Contents are not cleared by `rst`.
- States:
  - IDLE
    - `start` latches `last_frame` and `loop`, sets `ptr`=0, enters PULSE.
  - PULSE
    - On entry, all six layer words of frame `ptr` load into the output registers. These are the values driven for the whole pulse.
    - After PULSE_LEN clocks: go to GAP, or to the next PULSE if GAP_LEN=0.
  - GAP
    - Outputs are zero for GAP_LEN clocks.
    - Then, if `ptr`≠last: `ptr`+1, go to PULSE.
    - If `ptr`=last and the loop is active: `ptr`=0, go to PULSE.
    - Otherwise: go to IDLE and assert `done`.
  - With GAP_LEN=0, the end-of-frame decision is taken at the end of PULSE instead.
- `start` outside IDLE is ignored.
- A write to the frame currently being driven does not change the outputs until that frame is next entered.
- `trig_stop` high:
  - All `ly*` outputs are forced to zero the next clock.
  - The state, `ptr` and the pulse/gap counters freeze.
  - On release, the frozen frame is restored from its held output register and counting resumes where it left off.
  - `busy` stays high through the pause.
  - `trig_stop` in IDLE has no effect; `start` still accepted.
- `rst`, including mid-sequence:
  - Next clock: IDLE, `ptr`=0, `ly*`=0, `busy`=0, `done`=0, loop flag cleared.
- Reset values of all outputs are zero.
- Counter widths: `ptr` is log2(DEPTH). The pulse and gap counters are sized to hold PULSE_LEN and GAP_LEN.

## Timing
- `start` sampled at edge t:
  - frame 0 is visible on `ly*` and `busy`=1 from edge t+1;
  - it is held through edge t+PULSE_LEN;
  - zeros follow for GAP_LEN clocks.
- Frame k begins at edge t+1+k·(PULSE_LEN+GAP_LEN).
- `done` is high for the single clock after the final gap, coincident with `busy` falling.
- Total non-loop sequence length is (last+1)·(PULSE_LEN+GAP_LEN) clocks.
- `trig_stop` effect: one clock of latency on outputs, plus the number of paused clocks added to the schedule.
- A write at edge w is readable by any frame entered at edge w+1 or later.

## Configuration
- `INJ_LOOP_EN` defined:
  - `loop` is honoured.
  - A looping sequence runs until `rst`, and never pulses `done`.
- Not defined:
  - the `loop` port is present but ignored;
  - every sequence terminates after `last_frame`.

## Test plan
- Write frame 0, layers 0..5 = 0x00000001, 0x00000002, ..., 0x00000020. Then `last_frame`=0, `start` -> `ly0`=0x1 ... `ly5`=0x20 for 2 clocks, 3 zero clocks, then `done` pulse with `busy` falling.
- Frames 0..3 with distinct patterns, `last_frame`=3 -> four pulses starting at t+1, t+6, t+11, t+16; `done` at t+21.
- `trig_stop` high for 4 clocks during the second clock of frame 1 -> outputs zero for those 4 clocks. Frame 1 then resumes for exactly 1 more clock, and `done` is delayed by 4.
- `rst` asserted mid-GAP of frame 2 -> next clock all outputs 0, `busy`=0, no `done`. A new `start` replays from frame 0 with the store intact.
- `start` pulsed while `busy`, and a write to the active frame -> no restart, the current pulse is unchanged, and the new data appears on the next pass.
- `INJ_LOOP_EN` defined with `loop`=1 and `last_frame`=1 -> frames 0,1,0,1... repeat for 5 passes with no `done`. Without the macro -> a single pass, then `done`.

Source files
------------

// File: rtl/ly_hit_injector.sv
// Self-test hit source: replays stored six-layer wire-group frames as fixed-width pulses separated by gaps.
// Optional feature: define INJ_LOOP_EN to honour the loop input (continuous replay until rst).
module ly_hit_injector #(
  parameter int DEPTH     = 8,
  parameter int PULSE_LEN = 2,
  parameter int GAP_LEN   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [2:0]               wr_layer,
  input  logic [31:0]              wr_data,
  input  logic [$clog2(DEPTH)-1:0] last_frame,
  input  logic                     start,
  input  logic                     loop,
  input  logic                     trig_stop,
  output logic [31:0]              ly0,
  output logic [31:0]              ly1,
  output logic [31:0]              ly2,
  output logic [31:0]              ly3,
  output logic [31:0]              ly4,
  output logic [31:0]              ly5,
  output logic                     busy,
  output logic                     done
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(PULSE_LEN + 1);
  localparam int GW = (GAP_LEN > 0) ? $clog2(GAP_LEN + 1) : 1;
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE_LEN - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [AW-1:0]   last_q, last_d;
  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic [GW-1:0]   gcnt_q, gcnt_d;
  logic            loop_q, loop_d;
  logic            done_q, done_d;
  logic            load;
  logic            show;
  logic            end_frame;
  logic            loop_req;
  logic [31:0]     ly_w [6];

`ifdef INJ_LOOP_EN
  assign loop_req = loop;
`else
  logic unused_loop;
  assign loop_req    = 1'b0;
  assign unused_loop = loop;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      last_q  <= '0;
      pcnt_q  <= '0;
      gcnt_q  <= '0;
      loop_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      pcnt_q  <= pcnt_d;
      gcnt_q  <= gcnt_d;
      loop_q  <= loop_d;
      done_q  <= done_d;
    end
  end

  // load: fetch frame ptr_d into the output registers this edge.
  // show: keep driving the held frame; otherwise outputs go to zero.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    last_d    = last_q;
    pcnt_d    = pcnt_q;
    gcnt_d    = gcnt_q;
    loop_d    = loop_q;
    done_d    = 1'b0;
    load      = 1'b0;
    show      = 1'b0;
    end_frame = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = PULSE;
          ptr_d   = '0;
          last_d  = last_frame;
          loop_d  = loop_req;
          pcnt_d  = '0;
          load    = 1'b1;
        end
      end
      PULSE: begin
        if (!trig_stop) begin
          if (pcnt_q == PULSE_LAST) begin
            if (GAP_LEN == 0) begin
              end_frame = 1'b1;
            end else begin
              state_d = GAP;
              gcnt_d  = '0;
            end
          end else begin
            pcnt_d = pcnt_q + PW'(1);
            show   = 1'b1;
          end
        end
      end
      GAP: begin
        if (!trig_stop) begin
          if (gcnt_q == GAP_LAST) begin
            end_frame = 1'b1;
          end else begin
            gcnt_d = gcnt_q + GW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (end_frame) begin
      if (ptr_q != last_q) begin
        state_d = PULSE;
        ptr_d   = ptr_q + AW'(1);
        pcnt_d  = '0;
        load    = 1'b1;
      end else if (loop_q) begin
        state_d = PULSE;
        ptr_d   = '0;
        pcnt_d  = '0;
        load    = 1'b1;
      end else begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end

  // One RAM per layer so a single-word write and a six-word frame read coexist.
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_layer
      logic [31:0] mem [DEPTH];
      logic [31:0] frame_q;
      logic [31:0] ly_q;

      always_ff @(posedge clk) begin
        if (wr_en && (wr_layer == 3'(gi))) begin
          mem[wr_addr] <= wr_data;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          frame_q <= '0;
          ly_q    <= '0;
        end else if (load) begin
          frame_q <= mem[ptr_d];
          ly_q    <= mem[ptr_d];
        end else begin
          ly_q    <= show ? frame_q : '0;
        end
      end

      assign ly_w[gi] = ly_q;
    end
  endgenerate

  assign ly0  = ly_w[0];
  assign ly1  = ly_w[1];
  assign ly2  = ly_w[2];
  assign ly3  = ly_w[3];
  assign ly4  = ly_w[4];
  assign ly5  = ly_w[5];
  assign busy = (state_q != IDLE);
  assign done = done_q;

endmodule

// File: tb/tb_ly_hit_injector.sv
// Table-driven bench for ly_hit_injector: per-cycle vectors of inputs and expected outputs,
// expectations queued at each clock edge and compared on the following falling edge.
module tb_ly_hit_injector;
  localparam int DEPTH = 8;
  localparam int PL    = 2;
  localparam int GL    = 3;

  logic        clk = 1'b0;
  logic        rst, wr_en, start, loop, trig_stop;
  logic [2:0]  wr_addr, wr_layer, last_frame;
  logic [31:0] wr_data;
  logic [31:0] ly0, ly1, ly2, ly3, ly4, ly5;
  logic        busy, done;

  always #5 clk = ~clk;

  ly_hit_injector #(.DEPTH(DEPTH), .PULSE_LEN(PL), .GAP_LEN(GL)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_layer(wr_layer),
    .wr_data(wr_data), .last_frame(last_frame), .start(start), .loop(loop),
    .trig_stop(trig_stop), .ly0(ly0), .ly1(ly1), .ly2(ly2), .ly3(ly3), .ly4(ly4),
    .ly5(ly5), .busy(busy), .done(done)
  );

  // frame = -1 means all layers expected zero after the edge.
  typedef struct {
    bit          rst, start, trig, loop, wr_en;
    int          last, wr_addr, wr_layer, frame;
    logic [31:0] wr_data;
    bit          busy, done;
  } vec_t;

  typedef struct {
    logic [5:0][31:0] ly;
    logic             busy, done;
    int               idx;
  } exp_t;

  vec_t        vq[$];
  exp_t        sb[$];
  logic [31:0] shadow [DEPTH][6];
  int          n_vec = 0;
  int          n_bad = 0;

  function automatic void add(int n, int frame, bit b, bit d);
    vec_t v;
    v = '{default: 0};
    v.frame = frame;
    v.busy  = b;
    v.done  = d;
    for (int i = 0; i < n; i++) vq.push_back(v);
  endfunction

  function automatic void add_frame(int k);
    add(PL, k, 1'b1, 1'b0);
    add(GL, -1, 1'b1, 1'b0);
  endfunction

  function automatic void add_write(int a, int l, logic [31:0] d);
    add(1, -1, 1'b0, 1'b0);
    vq[vq.size()-1].wr_en    = 1'b1;
    vq[vq.size()-1].wr_addr  = a;
    vq[vq.size()-1].wr_layer = l;
    vq[vq.size()-1].wr_data  = d;
  endfunction

  function automatic void add_seq(int last, bit lp);
    int s;
    s = vq.size();
    for (int k = 0; k <= last; k++) add_frame(k);
    vq[s].start = 1'b1;
    vq[s].last  = last;
    vq[s].loop  = lp;
    add(1, -1, 1'b0, 1'b1);
  endfunction

  always @(negedge clk) begin
    exp_t             e;
    logic [5:0][31:0] act;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      act = {ly5, ly4, ly3, ly2, ly1, ly0};
      n_vec++;
      if (act !== e.ly || busy !== e.busy || done !== e.done) begin
        n_bad++;
        $display("FAIL vec%0d: got ly5..0=%h busy=%b done=%b, want ly5..0=%h busy=%b done=%b",
                 e.idx, act, busy, done, e.ly, e.busy, e.done);
      end
    end
  end

  initial begin
    int s, t;
    exp_t e;

    rst = 1'b1; wr_en = 1'b0; start = 1'b0; loop = 1'b0; trig_stop = 1'b0;
    wr_addr = '0; wr_layer = '0; wr_data = '0; last_frame = '0;

    // Reset, then load frames 0..3; writes to layers 6/7 must be dropped.
    add(2, -1, 1'b0, 1'b0);
    vq[0].rst = 1'b1;
    vq[1].rst = 1'b1;
    for (int l = 0; l < 6; l++) add_write(0, l, 32'h1 << l);
    for (int k = 1; k < 4; k++)
      for (int l = 0; l < 6; l++)
        add_write(k, l, {4'(k), 4'(l), 24'h5A3C96} ^ (32'h0101_0001 << (k + l)));
    add_write(2, 6, 32'hFFFF_FFFF);
    add_write(2, 7, 32'hEEEE_EEEE);

    // Single frame, then four frames back to back.
    add_seq(0, 1'b0);
    add(1, -1, 1'b0, 1'b0);
    add_seq(3, 1'b0);

    // Pause replaces the second clock of frame 1; start with trig_stop in IDLE is accepted.
    s = vq.size();
    add(PL, 0, 1'b1, 1'b0);
    add(GL, -1, 1'b1, 1'b0);
    add(1, 1, 1'b1, 1'b0);
    t = vq.size();
    add(4, -1, 1'b1, 1'b0);
    for (int j = t; j < t + 4; j++) vq[j].trig = 1'b1;
    add(1, 1, 1'b1, 1'b0);
    add(GL, -1, 1'b1, 1'b0);
    add_frame(2);
    add_frame(3);
    add(1, -1, 1'b0, 1'b1);
    vq[s].start = 1'b1;
    vq[s].trig  = 1'b1;
    vq[s].last  = 3;

    // Reset in the middle of frame 2's gap, then replay with the store intact.
    s = vq.size();
    add_frame(0);
    add_frame(1);
    add(PL, 2, 1'b1, 1'b0);
    add(1, -1, 1'b1, 1'b0);
    vq[s].start = 1'b1;
    vq[s].last  = 3;
    add(3, -1, 1'b0, 1'b0);
    vq[vq.size()-3].rst = 1'b1;
    add_seq(0, 1'b0);

    // start while busy is ignored; a write to the active frame shows only on the next pass.
    s = vq.size();
    add(PL, 0, 1'b1, 1'b0);
    add(GL, -1, 1'b1, 1'b0);
    vq[s].start      = 1'b1;
    vq[s].last       = 1;
    vq[s+1].start    = 1'b1;
    vq[s+1].last     = 0;
    vq[s+1].wr_en    = 1'b1;
    vq[s+1].wr_addr  = 0;
    vq[s+1].wr_layer = 0;
    vq[s+1].wr_data  = 32'hDEAD_BEEF;
    vq[s+2].start    = 1'b1;
    add_frame(1);
    add(1, -1, 1'b0, 1'b1);
    add_seq(0, 1'b0);

    // Loop request on frames 0..1.
    s = vq.size();
`ifdef INJ_LOOP_EN
    for (int p = 0; p < 5; p++) begin
      add_frame(0);
      add_frame(1);
    end
    vq[s].start = 1'b1;
    vq[s].last  = 1;
    vq[s].loop  = 1'b1;
    add(2, -1, 1'b0, 1'b0);
    vq[vq.size()-2].rst = 1'b1;
`else
    add_seq(1, 1'b1);
    add(3, -1, 1'b0, 1'b0);
`endif
    add_seq(1, 1'b0);
    add(1, -1, 1'b0, 1'b0);

    for (int i = 0; i < vq.size(); i++) begin
      rst        = vq[i].rst;
      start      = vq[i].start;
      trig_stop  = vq[i].trig;
      loop       = vq[i].loop;
      last_frame = 3'(vq[i].last);
      wr_en      = vq[i].wr_en;
      wr_addr    = 3'(vq[i].wr_addr);
      wr_layer   = 3'(vq[i].wr_layer);
      wr_data    = vq[i].wr_data;
      for (int l = 0; l < 6; l++)
        e.ly[l] = (vq[i].frame >= 0) ? shadow[vq[i].frame][l] : 32'h0;
      e.busy = vq[i].busy;
      e.done = vq[i].done;
      e.idx  = i;
      @(posedge clk);
      sb.push_back(e);
      if (vq[i].wr_en && vq[i].wr_layer < 6)
        shadow[vq[i].wr_addr][vq[i].wr_layer] = vq[i].wr_data;
      #1;
    end

    rst = 1'b0; start = 1'b0; wr_en = 1'b0; trig_stop = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
